gen_tx_stage_buffer: RTL and testbench

- Elastic buffer directly downstream of the generation controller.
- Captures each PIPE-cycle write (write strobe w, 64-bit byte-valid mask, encoding select sel) together with the 512-bit TX data word from the MAC.
- Presents the oldest entry to the lane-striping stage under a valid/ready handshake.
- Flushes on link-down and flags overflow.

---
 rtl/pcie_phy_pkg.sv | 25 ++
 rtl/gen_tx_buf_ptr.sv | 64 ++++++
 rtl/gen_tx_stage_buffer.sv | 103 ++++++++++
 tb/tb_gen_tx_stage_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions: generation encodings, encoding-path selects,
// default TX word geometry and the staged TX entry layout.
package pcie_phy_pkg;

    typedef enum logic [2:0] {
        GEN1 = 3'd1,
        GEN2 = 3'd2,
        GEN3 = 3'd3,
        GEN4 = 3'd4,
        GEN5 = 3'd5
    } gen_t;

    localparam logic SEL_8B10B    = 1'b0;
    localparam logic SEL_128B130B = 1'b1;

    localparam int PHY_MASK_W = 64;
    localparam int PHY_DATA_W = 8 * PHY_MASK_W;

    typedef struct packed {
        logic                  sel;
        logic [PHY_MASK_W-1:0] mask;
        logic [PHY_DATA_W-1:0] data;
    } tx_entry;

endpackage

// File: rtl/gen_tx_buf_ptr.sv
// Pointer, occupancy and overflow tracking for a circular elastic buffer.
// A low linkup flushes all state at the next edge; reset takes priority.
module gen_tx_buf_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     linkup,
    input  logic                     wr_req,
    input  logic                     rd_req,
    output logic                     wr_acc,
    output logic                     rd_acc,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

    logic [CW-1:0] count_next;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A read frees the head slot in the same cycle, so a full buffer can still take a write.
    assign rd_acc = linkup & ~empty & rd_req;
    assign wr_acc = linkup & wr_req & (~full | rd_acc);

    always_comb begin
        count_next = count;
        if (wr_acc & ~rd_acc)
            count_next = count + 1'b1;
        else if (rd_acc & ~wr_acc)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (!linkup) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            if (wr_req & ~wr_acc)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/gen_tx_stage_buffer.sv
// Elastic TX stage buffer between the generation controller and lane striping.
// Optional registered almost_full output is enabled by defining GEN_TX_BUF_AF_EN.
module gen_tx_stage_buffer
    import pcie_phy_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = PHY_DATA_W,
    parameter int MASK_W   = PHY_MASK_W,
    parameter int AF_LEVEL = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     linkup,
    input  logic                     w,
    input  logic [MASK_W-1:0]        valid,
    input  logic                     sel,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [MASK_W-1:0]        out_mask,
    output logic                     out_sel,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
`ifdef GEN_TX_BUF_AF_EN
    ,
    output logic                     almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [MASK_W-1:0] mem_mask [DEPTH];
    logic              mem_sel  [DEPTH];

    logic          wr_req;
    logic          wr_acc;
    logic          rd_acc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // All-zero masks never reach the pointer logic, so they neither store nor overflow.
    assign wr_req = w & (|valid);

    gen_tx_buf_ptr #(
        .DEPTH(DEPTH)
    ) u_ptr (
        .clk      (clk),
        .reset    (reset),
        .linkup   (linkup),
        .wr_req   (wr_req),
        .rd_req   (out_ready),
        .wr_acc   (wr_acc),
        .rd_acc   (rd_acc),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_data[wr_ptr] <= data_in;
            mem_mask[wr_ptr] <= valid;
            mem_sel[wr_ptr]  <= sel;
        end
    end

    // Head entry is only overwritten when rd_ptr advances in the same cycle, so a stalled output holds.
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem_data[rd_ptr];
    assign out_mask  = empty ? '0 : mem_mask[rd_ptr];
    assign out_sel   = empty ? SEL_8B10B : mem_sel[rd_ptr];

`ifdef GEN_TX_BUF_AF_EN
    localparam logic [AW:0] AF_THR = AF_LEVEL[AW:0];

    logic [AW:0] af_count_next;

    always_comb begin
        af_count_next = count;
        if (!linkup)
            af_count_next = '0;
        else if (wr_acc & ~rd_acc)
            af_count_next = count + 1'b1;
        else if (rd_acc & ~wr_acc)
            af_count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            almost_full <= 1'b0;
        else
            almost_full <= (af_count_next >= AF_THR);
    end
`endif

endmodule

// File: tb/tb_gen_tx_stage_buffer.sv
// Scoreboard bench for gen_tx_stage_buffer: queue-based reference model, directed
// scenarios followed by randomized traffic with flushes.
module tb_gen_tx_stage_buffer;

    localparam int DEPTH = 4;
    localparam int MW    = 64;
    localparam int DW    = 512;
    localparam int AF    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          linkup = 1'b0;
    logic          w = 1'b0;
    logic [MW-1:0] valid = '0;
    logic          sel = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [MW-1:0] out_mask;
    logic          out_sel;
    logic          full;
    logic          empty;
    logic [2:0]    count;
    logic          overflow;
`ifdef GEN_TX_BUF_AF_EN
    logic          almost_full;
`endif

    gen_tx_stage_buffer #(
        .DEPTH    (DEPTH),
        .DATA_W   (DW),
        .MASK_W   (MW),
        .AF_LEVEL (AF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .linkup    (linkup),
        .w         (w),
        .valid     (valid),
        .sel       (sel),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_sel   (out_sel),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
`ifdef GEN_TX_BUF_AF_EN
        ,
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sel;
        logic [MW-1:0] mask;
        logic [DW-1:0] data;
    } ent_t;

    ent_t exp_q[$];
    int   model_cnt = 0;
    bit   model_ovf = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++)
            d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // One cycle: check status produced by the last edge, then drive inputs for the next one.
    task automatic step(input bit rst, input bit lk, input bit wv, input logic [MW-1:0] m,
                        input bit s, input logic [DW-1:0] d, input bit rdy);
        bit rd;
        bit wr;
        @(posedge clk);
        #2;
        chk("count", DW'(count), DW'(model_cnt));
        chk("full", DW'(full), DW'(model_cnt == DEPTH));
        chk("empty", DW'(empty), DW'(model_cnt == 0));
        chk("out_valid", DW'(out_valid), DW'(model_cnt != 0));
        chk("overflow", DW'(overflow), DW'(model_ovf));
`ifdef GEN_TX_BUF_AF_EN
        chk("almost_full", DW'(almost_full), DW'(model_cnt >= AF));
`endif
        reset     = rst;
        linkup    = lk;
        w         = wv;
        valid     = m;
        sel       = s;
        data_in   = d;
        out_ready = rdy;
        if (rst || !lk) begin
            exp_q.delete();
            model_cnt = 0;
            model_ovf = 1'b0;
        end else begin
            rd = (model_cnt > 0) && rdy;
            wr = wv && (m != '0) && ((model_cnt < DEPTH) || rd);
            if (wv && (m != '0) && !wr)
                model_ovf = 1'b1;
            if (wr)
                exp_q.push_back('{sel: s, mask: m, data: d});
            model_cnt = model_cnt + int'(wr) - int'(rd);
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic wr(input logic [MW-1:0] m, input bit s, input bit rdy);
        step(1'b0, 1'b1, 1'b1, m, s, rand_data(), rdy);
    endtask

    // Monitor: head must match the oldest expected entry; pop on handshake.
    always @(negedge clk) begin
        if (!reset && linkup) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL head_present: got out_valid=1 expected no queued entry");
                end else begin
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_mask", DW'(out_mask), DW'(exp_q[0].mask));
                    chk("out_sel", DW'(out_sel), DW'(exp_q[0].sel));
                    if (out_ready)
                        void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_data", out_data, '0);
                chk("idle_mask", DW'(out_mask), '0);
                chk("idle_sel", DW'(out_sel), '0);
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(1'b0);

        // single write, one-cycle latency, then drain
        wr(64'h0000_0000_0000_00FF, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // fill, dropped 5th write, drain in order
        for (int i = 0; i < DEPTH; i++)
            wr(MW'($urandom) | 64'h1, 1'($urandom), 1'b0);
        wr(64'hFFFF_0000_FFFF_0000, 1'b1, 1'b0);
        idle(1'b0);
        for (int i = 0; i < DEPTH; i++)
            idle(1'b1);
        idle(1'b0);

        // flush clears overflow; full pass-through refill
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            wr(MW'($urandom) | 64'h80, 1'($urandom), 1'b0);
        wr(64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1);
        idle(1'b0);
        for (int i = 0; i < DEPTH; i++)
            idle(1'b1);

        // zero-mask write is discarded
        wr('0, 1'b1, 1'b0);
        idle(1'b0);

        // fill 3, flush with out_ready high, then normal writes
        for (int i = 0; i < 3; i++)
            wr(MW'($urandom) | 64'h2, 1'($urandom), 1'b0);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        idle(1'b0);
        wr(64'h0F, 1'b1, 1'b0);
        wr(64'hF0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // randomized streaming with occasional flushes and zero masks
        for (int i = 0; i < 400; i++) begin
            logic [MW-1:0] m;
            m = ($urandom_range(0, 7) == 0) ? '0 : MW'({$urandom, $urandom});
            step(1'b0, ($urandom_range(0, 59) != 0), 1'($urandom), m, 1'($urandom),
                 rand_data(), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < DEPTH + 2; i++)
            idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
